// File: rtl/deadlock_watchdog.sv
// Deadlock watchdog: qualifies a sustained block condition from the
// per-process deadlock monitors over CONFIRM_CYCLES consecutive cycles,
// then latches a one-shot report (lowest blocked monitor index plus
// stream/process block snapshots) that is held until acknowledged.
// The deadlock flag is sticky until reset.
module deadlock_watchdog #(
    parameter int MONITOR_NUM    = 4,
    parameter int CONFIRM_CYCLES = 1024,
    parameter int AXIS_W         = 12,
    parameter int IDLE_W         = 21,
    parameter int BLK_W          = 16,
    localparam int IDX_W         = (MONITOR_NUM > 1) ? $clog2(MONITOR_NUM) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MONITOR_NUM-1:0] monitor_block,
    input  logic [AXIS_W-1:0]      axis_block_sigs,
    input  logic [IDLE_W-1:0]      inst_idle_sigs,
    input  logic [BLK_W-1:0]       inst_block_sigs,
    input  logic                   report_ack,
    output logic                   report_valid,
    output logic [IDX_W-1:0]       report_idx,
    output logic [AXIS_W-1:0]      report_axis,
    output logic [BLK_W-1:0]       report_blk,
    output logic                   deadlock
);

    // Confirmation threshold in the width of the qualification counter
    localparam logic [15:0] CONFIRM_LIM = 16'(CONFIRM_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_REPORT  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_r;
    logic [15:0]       count_r;
    logic              any_block_s;
    logic              all_idle_s;
    logic              confirm_s;
    logic [IDX_W-1:0]  low_idx_s;

    // Index of the lowest set bit; zero when no bit is set
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MONITOR_NUM-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = MONITOR_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Reduce the live flags and decide whether this cycle completes qualification
    always_comb begin
        any_block_s = |monitor_block;
        all_idle_s  = &inst_idle_sigs;
        low_idx_s   = lowest_set(monitor_block);
        // In IDLE count_r is zero, so this also covers a one-cycle threshold
        confirm_s   = ((count_r + 16'd1) == CONFIRM_LIM);
    end

    // Qualification FSM with registered report outputs and sticky deadlock flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 16'd0;
            report_valid <= 1'b0;
            report_idx   <= {IDX_W{1'b0}};
            report_axis  <= {AXIS_W{1'b0}};
            report_blk   <= {BLK_W{1'b0}};
            deadlock     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_SUSPECT: begin
                    // Completion (all idle) wins over blockage; any gap restarts
                    if (all_idle_s || !any_block_s) begin
                        state_r <= ST_IDLE;
                        count_r <= 16'd0;
                    end else if (confirm_s) begin
                        state_r      <= ST_REPORT;
                        count_r      <= CONFIRM_LIM;
                        report_valid <= 1'b1;
                        deadlock     <= 1'b1;
                        report_idx   <= low_idx_s;
                        report_axis  <= axis_block_sigs;
                        report_blk   <= inst_block_sigs;
                    end else begin
                        state_r <= ST_SUSPECT;
                        count_r <= count_r + 16'd1;
                    end
                end
                ST_REPORT: begin
                    // Snapshots hold until the consumer accepts the report
                    if (report_ack) begin
                        state_r      <= ST_DONE;
                        report_valid <= 1'b0;
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    count_r      <= 16'd0;
                    report_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deadlock_watchdog.sv
// Scoreboard bench for deadlock_watchdog (CONFIRM_CYCLES=8, MONITOR_NUM=4).
// Stimulus pushes the expected report into a queue; a monitor pops and
// compares on every rising edge of report_valid.
module tb_deadlock_watchdog;

    localparam int CONF = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  monitor_block;
    logic [11:0] axis_block_sigs;
    logic [20:0] inst_idle_sigs;
    logic [15:0] inst_block_sigs;
    logic        report_ack;
    logic        report_valid;
    logic [1:0]  report_idx;
    logic [11:0] report_axis;
    logic [15:0] report_blk;
    logic        deadlock;

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] axis;
        logic [15:0] blk;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle_cnt = 0;
    logic prev_v = 1'b0;

    deadlock_watchdog #(
        .MONITOR_NUM(4), .CONFIRM_CYCLES(CONF), .AXIS_W(12), .IDLE_W(21), .BLK_W(16)
    ) dut (
        .clock(clock), .reset(reset), .monitor_block(monitor_block),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .report_ack(report_ack),
        .report_valid(report_valid), .report_idx(report_idx),
        .report_axis(report_axis), .report_blk(report_blk), .deadlock(deadlock)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle_cnt);
        end
    endtask

    // Monitor: compare each newly presented report against the scoreboard
    always @(negedge clock) begin
        if (report_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_report", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("report_idx", 32'(report_idx), 32'(e.idx));
                check("report_axis", 32'(report_axis), 32'(e.axis));
                check("report_blk", 32'(report_blk), 32'(e.blk));
                check("deadlock_on_report", 32'(deadlock), 32'd1);
                check("report_latency", 32'(cycle_cnt), 32'(e.cyc));
            end
        end
        prev_v <= report_valid;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_report(input logic [1:0] idx, input logic [11:0] axis,
                                 input logic [15:0] blk);
        exp_t e;
        e.idx = idx; e.axis = axis; e.blk = blk; e.cyc = cycle_cnt + CONF;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            check("report_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic quiet_inputs();
        monitor_block = 4'd0; axis_block_sigs = 12'd0; inst_idle_sigs = 21'd0;
        inst_block_sigs = 16'd0; report_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step(2);
        check({tag, "_rst_valid"}, 32'(report_valid), 32'd0);
        check({tag, "_rst_deadlock"}, 32'(deadlock), 32'd0);
        check({tag, "_rst_idx"}, 32'(report_idx), 32'd0);
        check({tag, "_rst_axis"}, 32'(report_axis), 32'd0);
        check({tag, "_rst_blk"}, 32'(report_blk), 32'd0);
        quiet_inputs();
        reset = 1'b0;
    endtask

    task automatic ack_and_check(input string tag);
        check({tag, "_valid_before_ack"}, 32'(report_valid), 32'd1);
        report_ack = 1'b1;
        step();
        report_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(report_valid), 32'd0);
        check({tag, "_deadlock_after_ack"}, 32'(deadlock), 32'd1);
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        step(1);
        do_reset("init");

        // Single monitor blocked continuously: report after CONF cycles, idx 2
        axis_block_sigs = 12'h0A5; inst_block_sigs = 16'h1234;
        monitor_block = 4'b0100;
        expect_report(2'd2, 12'h0A5, 16'h1234);
        wait_drain(CONF + 4);
        ack_and_check("basic");
        do_reset("basic");

        // One unblocked cycle after 7 restarts qualification
        inst_block_sigs = 16'h00FF;
        monitor_block = 4'b0001;
        step(7);
        monitor_block = 4'b0000;
        step(1);
        monitor_block = 4'b0001;
        expect_report(2'd0, 12'h000, 16'h00FF);
        wait_drain(CONF + 4);
        ack_and_check("gap");
        do_reset("gap");

        // Completion (all idle) cancels a pending suspicion; no report
        monitor_block = 4'b1000;
        step(5);
        inst_idle_sigs = {21{1'b1}};
        step(20);
        check("idle_no_valid", 32'(report_valid), 32'd0);
        check("idle_no_deadlock", 32'(deadlock), 32'd0);
        do_reset("idle");

        // Report held while ack low and inputs churn; then ack, then DONE absorbs
        axis_block_sigs = 12'h00F; inst_block_sigs = 16'hBEEF;
        monitor_block = 4'b0010;
        expect_report(2'd1, 12'h00F, 16'hBEEF);
        wait_drain(CONF + 4);
        for (int i = 0; i < 20; i++) begin
            axis_block_sigs = ~axis_block_sigs;
            inst_block_sigs = 16'(i * 16'h1111);
            monitor_block = 4'(i);
            inst_idle_sigs = (i % 2 == 0) ? {21{1'b1}} : 21'd0;
            step();
            check("hold_valid", 32'(report_valid), 32'd1);
            check("hold_axis", 32'(report_axis), 32'h00F);
            check("hold_blk", 32'(report_blk), 32'hBEEF);
            check("hold_idx", 32'(report_idx), 32'd1);
        end
        inst_idle_sigs = 21'd0;
        monitor_block = 4'b0001;
        ack_and_check("hold");
        step(3 * CONF);
        report_ack = 1'b1;
        step(2);
        report_ack = 1'b0;
        check("done_no_valid", 32'(report_valid), 32'd0);
        check("done_deadlock_sticky", 32'(deadlock), 32'd1);
        do_reset("done");

        // Lowest set index among several blocked monitors
        axis_block_sigs = 12'hF00; inst_block_sigs = 16'h8001;
        monitor_block = 4'b1010;
        expect_report(2'd1, 12'hF00, 16'h8001);
        wait_drain(CONF + 4);
        ack_and_check("lowidx");
        do_reset("lowidx");

        // Reset mid-count: full re-qualification afterwards
        inst_block_sigs = 16'h0420;
        monitor_block = 4'b0100;
        step(5);
        reset = 1'b1;
        step(1);
        check("midcount_rst_valid", 32'(report_valid), 32'd0);
        check("midcount_rst_deadlock", 32'(deadlock), 32'd0);
        reset = 1'b0;
        expect_report(2'd2, 12'h000, 16'h0420);
        wait_drain(CONF + 4);
        ack_and_check("requal");

        step(2);
        if (exp_q.size() != 0) check("leftover_expect", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/deadlock_watchdog.md
DEADLOCK_WATCHDOG -- requirements
Module: deadlock_watchdog

Interface
REQ-001 SHALL have parameter MONITOR_NUM, default 4: number of per-process deadlock monitor block inputs.
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 1024: consecutive blocked cycles required to declare deadlock; legal range 1..65535.
REQ-003 SHALL have parameter AXIS_W, default 12: width of the stream block vector.
REQ-004 SHALL have parameter IDLE_W, default 21: width of the process idle vector.
REQ-005 SHALL have parameter BLK_W, default 16: width of the process block vector.
REQ-006 SHALL have port clock  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port monitor_block  input  MONITOR_NUM  block flags from the per-process deadlock monitors.
REQ-009 SHALL have port axis_block_sigs  input  AXIS_W  live stream-blocked flags.
REQ-010 SHALL have port inst_idle_sigs  input  IDLE_W  live process idle flags.
REQ-011 SHALL have port inst_block_sigs  input  BLK_W  live process blocked flags.
REQ-012 SHALL have port report_ack  input  1  consumer accepts the report.
REQ-013 SHALL have port report_valid  output  1  deadlock report pending.
REQ-014 SHALL have port report_idx  output  max(1,clog2(MONITOR_NUM))  lowest-numbered monitor blocked at confirmation.
REQ-015 SHALL have port report_axis  output  AXIS_W  axis_block_sigs snapshot.
REQ-016 SHALL have port report_blk  output  BLK_W  inst_block_sigs snapshot.
REQ-017 SHALL have port deadlock  output  1  sticky deadlock flag.

Function
REQ-018 SHALL define any_block = OR of monitor_block; all_idle = AND of inst_idle_sigs; both sampled at the rising edge.
REQ-019 SHALL implement FSM states IDLE, SUSPECT, REPORT, DONE; all outputs registered.
REQ-020 IDLE: any_block and not all_idle -> SUSPECT with count=1; if CONFIRM_CYCLES==1 -> REPORT directly; else stay.
REQ-021 SUSPECT: all_idle -> IDLE, count=0 (completion has priority over blockage).
REQ-022 SUSPECT: any_block low -> IDLE, count=0 (any single unblocked cycle restarts qualification).
REQ-023 SUSPECT: any_block high and count+1 == CONFIRM_CYCLES -> REPORT; else count increments.
REQ-024 count SHALL be 16 bits, never exceed CONFIRM_CYCLES, never wrap.
REQ-025 On the edge entering REPORT: capture report_idx = lowest set index of monitor_block, report_axis, report_blk from the same sampled cycle; report_valid=1.
REQ-026 Latency: any_block high in sampled cycles k..k+CONFIRM_CYCLES-1 -> report_valid high from cycle k+CONFIRM_CYCLES.
REQ-027 REPORT: report_valid and snapshots hold stable until report_ack sampled high; inputs ignored, including all_idle.
REQ-028 REPORT with report_ack high -> DONE; report_valid low next cycle.
REQ-029 deadlock SHALL rise with report_valid and remain high in DONE until reset.
REQ-030 DONE: absorbing; no new report, inputs ignored.
REQ-031 report_ack outside REPORT SHALL have no effect.

Reset
REQ-032 reset SHALL take priority over all conditions, including mid-count and mid-report.
REQ-033 After reset: state IDLE, count=0, report_valid=0, deadlock=0, report_idx=0, report_axis=0, report_blk=0.

Verification
REQ-034 CONFIRM_CYCLES=8, monitor_block=4'b0100 from cycle 10 -> report_valid=1 at cycle 18, report_idx=2, deadlock=1.
REQ-035 CONFIRM_CYCLES=8, block high 7 cycles, low 1, high 8 -> single report, 8 cycles after second rise.
REQ-036 Blocked 5 cycles then inst_idle_sigs all ones -> state IDLE, no report_valid.
REQ-037 In REPORT, report_ack held low 20 cycles while axis_block_sigs toggles -> snapshots unchanged; ack pulse -> report_valid=0 next cycle, deadlock stays 1.
REQ-038 monitor_block=4'b1010 at confirmation, axis_block_sigs=12'hF00 -> report_idx=1, report_axis=12'hF00.
REQ-039 reset asserted at count=5 and separately in DONE -> all outputs 0, re-qualification needs full CONFIRM_CYCLES.
